mem_stage_lsu: RTL

- Parametrised successor to the single-cycle memory stage: MEM/WB pipeline register plus a load/store unit.
- Adds byte/half/word (and double at XLEN=64) access sizing, lane byte enables and load sign/zero extension.
- Talks to data memory over a req/gnt/rvalid handshake with variable latency, and raises stall_m to the hazard unit.
- Sits between the EX/MEM register and the write-back mux.

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/mem_stage_lsu_align.sv | 30 +++
 rtl/mem_stage_lsu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Sizes, FSM states, lane enable / store replicate / load extend.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B, SZ_H, SZ_W, SZ_D
  } size_e;

  typedef enum logic {
    IDLE, WAIT_RESP
  } lsu_state_e;

  // Helpers work on the 64-bit superset; callers
  // narrow the result to their own XLEN.
  function automatic logic [7:0] be_gen(
    size_e size, logic [2:0] off
  );
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] store_align(
    size_e size, logic [63:0] d
  );
    logic [63:0] r;
    case (size)
      SZ_B:    r = {8{d[7:0]}};
      SZ_H:    r = {4{d[15:0]}};
      SZ_W:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] load_extend(
    size_e size, logic uns,
    logic [2:0] off, logic [63:0] rdata
  );
    logic [63:0] sh;
    logic [63:0] r;
    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_B: r = uns ? {56'b0, sh[7:0]}
                    : {{56{sh[7]}}, sh[7:0]};
      SZ_H: r = uns ? {48'b0, sh[15:0]}
                    : {{48{sh[15]}}, sh[15:0]};
      SZ_W: r = uns ? {32'b0, sh[31:0]}
                    : {{32{sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane alignment: store byte enables / replicated data, load extract.
// Ports: st_* store side, ld_* load side, rdata in, ld_data out.
module mem_stage_lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        st_size,
  input  logic [2:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  input  logic [2:0]        ld_off,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ld_data
);

  localparam int NB = XLEN / 8;

  assign be = NB'(be_gen(size_e'(st_size), st_off));

  assign wdata = XLEN'(store_align(
    size_e'(st_size), 64'(st_data)));

  assign ld_data = XLEN'(load_extend(
    size_e'(ld_size), ld_uns, ld_off, 64'(rdata)));

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM/WB register plus load/store unit with req/gnt/rvalid dmem port.
// Ports: M-stage fields in, dmem handshake, stall_m, W-stage fields out.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              valid_m,
  input  logic [REG_W-1:0]  rd_m,
  input  logic [XLEN-1:0]   alu_result_m,
  input  logic [XLEN-1:0]   write_data_m,
  input  logic [XLEN-1:0]   pc_plus4_m,
  input  logic              reg_write_m,
  input  logic [1:0]        result_src_m,
  input  logic              mem_write_m,
  input  logic              mem_read_m,
  input  logic [2:0]        funct3_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall_m,
  output logic [REG_W-1:0]  rd_w,
  output logic [XLEN-1:0]   alu_result_w,
  output logic [XLEN-1:0]   pc_plus4_w,
  output logic              reg_write_w,
  output logic [1:0]        result_src_w,
  output logic [XLEN-1:0]   read_data_w,
  output logic              valid_w,
  output logic              misalign_w
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("mem_stage_lsu: XLEN must be 32 or 64");
  end

  lsu_state_e        state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;

  logic [REG_W-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              rw_q, rw_d;
  logic [1:0]        rsrc_q, rsrc_d;
  logic [XLEN-1:0]   rdat_q, rdat_d;
  logic              vld_q, vld_d;
  logic              mis_q, mis_d;

  size_e             size;
  logic [OFF_W-1:0]  off;
  logic              access;
  logic              mis;
  logic              ok_acc;
  logic              is_ld;
  logic [ADDR_W-1:0] ea;
  logic [XLEN-1:0]   ld_data;

  assign size   = size_e'(funct3_m[1:0]);
  assign off    = alu_result_m[OFF_W-1:0];
  assign access = valid_m & (mem_read_m | mem_write_m);
  assign is_ld  = mem_read_m;
  assign ok_acc = access & ~mis;
  assign ea     = ADDR_W'(alu_result_m);

  // Lane bits are zeroed; they only steer dmem_be.
  assign dmem_addr = {ea[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign dmem_we   = dmem_req & ~is_ld;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      size == SZ_H: mis = alu_result_m[0];
      size == SZ_W: mis = |alu_result_m[1:0];
      size == SZ_D: mis = (XLEN == 32) |
                          (|alu_result_m[2:0]);
      default:      mis = 1'b0;
    endcase
  end

  mem_stage_lsu_align #(.XLEN(XLEN)) u_align (
    .st_size (funct3_m[1:0]),
    .st_off  (3'(off)),
    .st_data (write_data_m),
    .be      (dmem_be),
    .wdata   (dmem_wdata),
    .ld_size (size_q),
    .ld_uns  (uns_q),
    .ld_off  (3'(off_q)),
    .rdata   (dmem_rdata),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    dmem_req = 1'b0;
    stall_m  = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req = ok_acc;
        // Only a granted store leaves M this cycle.
        stall_m  = ok_acc & ~(dmem_gnt & ~is_ld);
        if (ok_acc & dmem_gnt & is_ld) begin
          state_d = WAIT_RESP;
          off_d   = off;
          size_d  = size;
          uns_d   = funct3_m[2];
        end
      end
      WAIT_RESP: begin
        stall_m = ~dmem_rvalid;
        if (dmem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d   = rd_q;
    alu_d  = alu_q;
    pc4_d  = pc4_q;
    rsrc_d = rsrc_q;
    rdat_d = rdat_q;
    vld_d  = 1'b0;
    rw_d   = 1'b0;
    mis_d  = 1'b0;
    if (!stall_m) begin
      rd_d   = rd_m;
      alu_d  = alu_result_m;
      pc4_d  = pc_plus4_m;
      rsrc_d = result_src_m;
      vld_d  = valid_m;
      mis_d  = access & mis;
      rw_d   = valid_m & reg_write_m &
               ~(access & mis);
      rdat_d = (state_q == WAIT_RESP)
               ? ld_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
      rw_q    <= 1'b0;
      rsrc_q  <= '0;
      rdat_q  <= '0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      pc4_q   <= pc4_d;
      rw_q    <= rw_d;
      rsrc_q  <= rsrc_d;
      rdat_q  <= rdat_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  assign rd_w         = rd_q;
  assign alu_result_w = alu_q;
  assign pc_plus4_w   = pc4_q;
  assign reg_write_w  = rw_q;
  assign result_src_w = rsrc_q;
  assign read_data_w  = rdat_q;
  assign valid_w      = vld_q;
  assign misalign_w   = mis_q;

endmodule
